lfsr_gen: RTL and testbench

//  Parametrised LFSR pseudo-random generator. Supports configurable width, feedback taps and seed,
//  run-time Fibonacci/Galois mode, and STEPS shifts per enabled cycle. Adds seed load, all-zero

---
 rtl/lfsr_gen.sv | 136 +++++++++++++
 tb/tb_lfsr_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator: Fibonacci/Galois selectable per cycle, STEPS shifts per advance,
// seed load, all-zero lock-up recovery and period measurement between returns to the start state.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b1000,
  parameter int unsigned      STEPS = 1,
  parameter int unsigned      CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_galois,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic [STEPS-1:0] dout,
  output logic             dout_valid,
  output logic             lockup,
  output logic             wrap,
  output logic [CW-1:0]    period
);

  localparam int unsigned SW = CW + 32;

  // Stream contract: dout carries new bits exactly in cycles where dout_valid=1;
  // there is no back-pressure, every enabled advance is emitted once.
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [STEPS-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    period_q, period_d;

  logic [WIDTH-1:0] walk;
  logic [STEPS:0]   bits_tmp;
  logic             hit;
  int unsigned      hit_k;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] s, input logic galois);
    if (galois) begin
      return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS);
    end
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // Counter add that clamps at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input int unsigned b);
    logic [SW-1:0] sum;
    sum = SW'(a) + SW'(b);
    if (|sum[SW-1:CW]) begin
      return '1;
    end
    return sum[CW-1:0];
  endfunction

  always_comb begin
    walk     = state_q;
    bits_tmp = '0;
    hit      = 1'b0;
    hit_k    = 0;
    // Bits enter at the top and drift down, so the first emitted bit lands at dout[0].
    for (int unsigned k = 1; k <= STEPS; k++) begin
      bits_tmp = {walk[WIDTH-1], bits_tmp[STEPS:1]};
      walk     = shift_one(walk, mode_galois);
      if (!hit && (walk == start_q)) begin
        hit   = 1'b1;
        hit_k = k;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    lockup_d     = 1'b0;
    wrap_d       = 1'b0;
    cnt_d        = cnt_q;
    period_d     = period_q;
    if (load) begin
      state_d = load_val;
      start_d = load_val;
      cnt_d   = '0;
    end else if (en && (state_q == '0)) begin
      state_d  = SEED;
      start_d  = SEED;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (en) begin
      state_d      = walk;
      dout_d       = bits_tmp[STEPS:1];
      dout_valid_d = 1'b1;
      if (hit) begin
        wrap_d   = 1'b1;
        period_d = sat_add(cnt_q, hit_k);
        cnt_d    = CW'(STEPS - hit_k);
      end else begin
        cnt_d = sat_add(cnt_q, STEPS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SEED;
      start_q      <= SEED;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      lockup_q     <= 1'b0;
      wrap_q       <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      lockup_q     <= lockup_d;
      wrap_q       <= wrap_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
    end
  end

  assign state      = state_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign lockup     = lockup_q;
  assign wrap       = wrap_q;
  assign period     = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: four parameterisations driven by shared stimulus, each checked against
// an arithmetic reference model, plus a directed vector table and hand-written corner sequences.
module tb_lfsr_gen;

  logic       clk, rst, en, mode_galois, load;
  logic [3:0] load_val;

  logic [3:0] state_a, state_g, state_s, state_c;
  logic [0:0] dout_a, dout_g, dout_c;
  logic [2:0] dout_s;
  logic       dv_a, dv_g, dv_s, dv_c;
  logic       lk_a, lk_g, lk_s, lk_c;
  logic       wr_a, wr_g, wr_s, wr_c;
  logic [15:0] period_a, period_g, period_s;
  logic [2:0]  period_c;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b1000), .STEPS(1), .CW(16)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode_galois(mode_galois), .load(load), .load_val(load_val),
    .state(state_a), .dout(dout_a), .dout_valid(dv_a), .lockup(lk_a), .wrap(wr_a), .period(period_a));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'b1000), .STEPS(1), .CW(16)) u_g (
    .clk(clk), .rst(rst), .en(en), .mode_galois(mode_galois), .load(load), .load_val(load_val),
    .state(state_g), .dout(dout_g), .dout_valid(dv_g), .lockup(lk_g), .wrap(wr_g), .period(period_g));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b1000), .STEPS(3), .CW(16)) u_s (
    .clk(clk), .rst(rst), .en(en), .mode_galois(mode_galois), .load(load), .load_val(load_val),
    .state(state_s), .dout(dout_s), .dout_valid(dv_s), .lockup(lk_s), .wrap(wr_s), .period(period_s));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b1000), .STEPS(1), .CW(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode_galois(mode_galois), .load(load), .load_val(load_val),
    .state(state_c), .dout(dout_c), .dout_valid(dv_c), .lockup(lk_c), .wrap(wr_c), .period(period_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] state;
    logic [3:0] start;
    logic [3:0] dout;
    logic       dv;
    logic       lk;
    logic       wr;
    int         cnt;
    int         period;
  } mdl_t;

  typedef struct {
    logic       en;
    logic       ld;
    logic       gal;
    logic [3:0] lv;
    logic [3:0] st;
    logic       dout;
    logic       dv;
    logic       lk;
  } vec_t;

  mdl_t m[4];
  vec_t tbl[12];
  int   taps_t[4]  = '{12, 3, 12, 12};
  int   steps_t[4] = '{1, 1, 3, 1};
  int   cwmax_t[4] = '{65535, 65535, 65535, 7};
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic mdl_t model_reset();
    mdl_t r;
    r.state = 4'd8; r.start = 4'd8; r.dout = 4'd0;
    r.dv = 1'b0; r.lk = 1'b0; r.wr = 1'b0;
    r.cnt = 0; r.period = 0;
    return r;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // One clock of the reference behaviour, evaluated on integers.
  function automatic mdl_t model_step(mdl_t cur, int idx);
    mdl_t r;
    int   s, b, nsteps;
    bit   hit;
    r = cur; r.dv = 1'b0; r.lk = 1'b0; r.wr = 1'b0;
    nsteps = steps_t[idx];
    if (load) begin
      r.state = load_val; r.start = load_val; r.cnt = 0;
    end else if (en && cur.state == 4'd0) begin
      r.state = 4'd8; r.start = 4'd8; r.cnt = 0; r.lk = 1'b1;
    end else if (en) begin
      s = int'(cur.state);
      hit = 1'b0;
      r.dout = 4'd0;
      for (int i = 0; i < nsteps; i++) begin
        b = (s >> 3) & 1;
        if (b == 1) r.dout = r.dout | (4'd1 << i);
        if (mode_galois) s = ((s * 2) % 16) ^ ((b == 1) ? taps_t[idx] : 0);
        else             s = ((s * 2) % 16) + ($countones(s & taps_t[idx]) % 2);
        if (!hit && s == int'(cur.start)) begin
          hit = 1'b1;
          r.wr = 1'b1;
          r.period = imin(cur.cnt + i + 1, cwmax_t[idx]);
          r.cnt = nsteps - i - 1;
        end
      end
      if (!hit) r.cnt = imin(cur.cnt + nsteps, cwmax_t[idx]);
      r.state = s[3:0];
      r.dv = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack(logic [3:0] st, logic [3:0] d, logic dv, logic lk,
                                       logic wr, logic [15:0] per);
    return {4'd0, st, d, dv, lk, wr, 1'b0, per};
  endfunction

  // scoreboard
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(string tag);
    check({tag, "/a"}, pack(state_a, {3'd0, dout_a}, dv_a, lk_a, wr_a, period_a),
          pack(m[0].state, m[0].dout, m[0].dv, m[0].lk, m[0].wr, 16'(m[0].period)));
    check({tag, "/g"}, pack(state_g, {3'd0, dout_g}, dv_g, lk_g, wr_g, period_g),
          pack(m[1].state, m[1].dout, m[1].dv, m[1].lk, m[1].wr, 16'(m[1].period)));
    check({tag, "/s"}, pack(state_s, {1'b0, dout_s}, dv_s, lk_s, wr_s, period_s),
          pack(m[2].state, m[2].dout, m[2].dv, m[2].lk, m[2].wr, 16'(m[2].period)));
    check({tag, "/c"}, pack(state_c, {3'd0, dout_c}, dv_c, lk_c, wr_c, {13'd0, period_c}),
          pack(m[3].state, m[3].dout, m[3].dv, m[3].lk, m[3].wr, 16'(m[3].period)));
  endtask

  // driver tasks
  task automatic step(string tag);
    @(posedge clk);
    for (int i = 0; i < 4; i++) m[i] = model_step(m[i], i);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(string tag);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m[i] = model_reset();
    compare_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; mode_galois = 1'b0;
    //          en    ld    gal   lv     st     dout  dv    lk
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b1001, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'h6, 4'b0110, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b1101, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b1010, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'b0010, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) m[i] = model_reset();

    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors on the default configuration.
    foreach (tbl[i]) begin
      en = tbl[i].en; load = tbl[i].ld; mode_galois = tbl[i].gal; load_val = tbl[i].lv;
      step("table");
      check("table_a", 32'({state_a, dout_a, dv_a, lk_a, wr_a}),
            32'({tbl[i].st, tbl[i].dout, tbl[i].dv, tbl[i].lk, 1'b0}));
    end

    // Async reset mid-run, then a full period twice with en held.
    en = 1'b0; load = 1'b0; mode_galois = 1'b0;
    async_reset("async_mid");
    en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step("run");
      check("t1_wrap", 32'(wr_a), 32'((c == 15) || (c == 30)));
      check("t6_wrap", 32'(wr_c), 32'((c == 15) || (c == 30)));
      if (c == 5) check("t4_wrap_period", 32'({wr_s, period_s}), 32'({1'b1, 16'd15}));
      if (c == 15) begin
        check("t1_state", 32'(state_a), 32'd8);
        check("t1_period", 32'(period_a), 32'd15);
        check("t6_period", 32'(period_c), 32'd7);
      end
    end

    // Galois from a loaded start value.
    en = 1'b0; mode_galois = 1'b1; load = 1'b1; load_val = 4'b1000;
    step("gal_load");
    load = 1'b0; en = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step("gal_run");
      if (c == 1) check("t2_first", 32'({state_g, dout_g}), 32'({4'b0011, 1'b1}));
      check("t2_wrap", 32'(wr_g), 32'(c == 15));
      if (c == 15) check("t2_period", 32'(period_g), 32'd15);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      en = ($urandom_range(0, 9) < 7);
      load = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) load_val = 4'd0;
      if ($urandom_range(0, 9) == 0) mode_galois = ~mode_galois;
      if ($urandom_range(0, 199) == 0) async_reset("async_rand");
      step("rand");
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
